// File: rtl/alu_pkg.sv
// Shared constants for the 6-bit ALU datapath: widths, sequencer state encoding
// and the function-select codes understood by the ripple-adder ALU.
package alu_pkg;

  localparam int ALU_DATA_W = 6;
  localparam int ALU_FXN_W  = 3;

  // Encodings are mirrored directly onto the board LEDs
  typedef enum logic [2:0] {
    ST_LOAD_A = 3'b000,
    ST_LOAD_B = 3'b001,
    ST_LOAD_F = 3'b010,
    ST_SETTLE = 3'b011,
    ST_SHOW   = 3'b100
  } state_e;

  localparam logic [ALU_FXN_W-1:0] FXN_ADD    = 3'd0;
  localparam logic [ALU_FXN_W-1:0] FXN_SUB    = 3'd1;
  localparam logic [ALU_FXN_W-1:0] FXN_AND    = 3'd2;
  localparam logic [ALU_FXN_W-1:0] FXN_OR     = 3'd3;
  localparam logic [ALU_FXN_W-1:0] FXN_XOR    = 3'd4;
  localparam logic [ALU_FXN_W-1:0] FXN_NOT_A  = 3'd5;
  localparam logic [ALU_FXN_W-1:0] FXN_PASS_A = 3'd6;
  localparam logic [ALU_FXN_W-1:0] FXN_PASS_B = 3'd7;

endpackage

// File: rtl/btn_debounce.sv
// Conditions one raw push-button: 2-flop synchronizer, stable-level debounce
// and a single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any cycle where the synchronized input agrees with the accepted level restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    pulse_d = level_d & ~level_q;
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and fxn from the switches via debounced Enter, issues them to the
// ALU as registered operands, waits for the ripple chain to settle and latches the result.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W          = ALU_DATA_W,
  parameter int FXN_W           = ALU_FXN_W,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_enter,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [FXN_W-1:0]  op_fxn,
  output logic              op_valid,
  input  logic [DATA_W-1:0] res_in,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [2:0]        state_led
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  logic              enter_p, clear_p;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [FXN_W-1:0]  op_fxn_q, op_fxn_d;
  logic              op_valid_q, op_valid_d, result_valid_q, result_valid_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic              wipe;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_enter), .pulse(enter_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clear), .pulse(clear_p)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_LOAD_A;
      op_a_q         <= '0;
      op_b_q         <= '0;
      op_fxn_q       <= '0;
      op_valid_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      settle_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      op_fxn_q       <= op_fxn_d;
      op_valid_q     <= op_valid_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      settle_cnt_q   <= settle_cnt_d;
    end
  end

  // Clear wins over Enter everywhere; unused encodings fall back to LOAD_A
  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = ST_LOAD_A;
    end else begin
      case (state_q)
        ST_LOAD_A: if (enter_p) state_d = ST_LOAD_B;
        ST_LOAD_B: if (enter_p) state_d = ST_LOAD_F;
        ST_LOAD_F: if (enter_p) state_d = ST_SETTLE;
        ST_SETTLE: if (settle_cnt_q == SETTLE_LAST) state_d = ST_SHOW;
        ST_SHOW:   if (enter_p) state_d = ST_LOAD_A;
        default:   state_d = ST_LOAD_A;
      endcase
    end
  end

  always_comb begin
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    op_fxn_d       = op_fxn_q;
    op_valid_d     = op_valid_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    settle_cnt_d   = settle_cnt_q;
    wipe           = clear_p;
    if (!clear_p) begin
      case (state_q)
        ST_LOAD_A: if (enter_p) op_a_d = sw;
        ST_LOAD_B: if (enter_p) op_b_d = sw;
        ST_LOAD_F: begin
          if (enter_p) begin
            op_fxn_d     = sw[FXN_W-1:0];
            op_valid_d   = 1'b1;
            settle_cnt_d = '0;
          end
        end
        ST_SETTLE: begin
          settle_cnt_d = settle_cnt_q + 1'b1;
          if (settle_cnt_q == SETTLE_LAST) begin
            result_d       = res_in;
            result_valid_d = 1'b1;
          end
        end
        ST_SHOW: begin
          if (enter_p) begin
            op_valid_d     = 1'b0;
            result_valid_d = 1'b0;
          end
        end
        default: wipe = 1'b1;
      endcase
    end
    if (wipe) begin
      op_a_d         = '0;
      op_b_d         = '0;
      op_fxn_d       = '0;
      op_valid_d     = 1'b0;
      result_d       = '0;
      result_valid_d = 1'b0;
      settle_cnt_d   = '0;
    end
  end

  always_comb begin
    state_led    = state_q;
    op_a         = op_a_q;
    op_b         = op_b_q;
    op_fxn       = op_fxn_q;
    op_valid     = op_valid_q;
    result       = result_q;
    result_valid = result_valid_q;
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed scenarios for the operand sequencer with short debounce and settle times.
module tb_alu_operand_sequencer;

  logic       clk;
  logic       rst_n;
  logic [5:0] sw;
  logic       btn_enter;
  logic       btn_clear;
  logic [5:0] op_a;
  logic [5:0] op_b;
  logic [2:0] op_fxn;
  logic       op_valid;
  logic [5:0] res_in;
  logic [5:0] result;
  logic       result_valid;
  logic [2:0] state_led;

  int passed = 0;
  int total  = 0;

  alu_operand_sequencer #(
    .DATA_W(6), .FXN_W(3), .DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .op_a(op_a), .op_b(op_b), .op_fxn(op_fxn), .op_valid(op_valid), .res_in(res_in),
    .result(result), .result_valid(result_valid), .state_led(state_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full press/release; long enough for the debouncer to accept both edges
  task automatic press_enter(input logic [5:0] val);
    sw = val;
    btn_enter = 1'b1;
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    repeat (12) @(negedge clk);
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_op_valid(output bit found);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (op_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    press_enter(6'd21);
    total++; if (op_a !== 6'd21) $display("[TB] FAIL rst_preload_op_a: got %0d expected 21", op_a); else passed++;
    total++; if (state_led !== 3'b001) $display("[TB] FAIL rst_preload_state: got %b expected 001", state_led); else passed++;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (op_a !== 6'd0) $display("[TB] FAIL rst_async_op_a: got %0d expected 0", op_a); else passed++;
    total++; if (state_led !== 3'b000) $display("[TB] FAIL rst_async_state: got %b expected 000", state_led); else passed++;
    total++; if ({op_valid, result_valid} !== 2'b00) $display("[TB] FAIL rst_async_valids: got %b expected 00", {op_valid, result_valid}); else passed++;
    total++; if ({op_b, op_fxn, result} !== 15'd0) $display("[TB] FAIL rst_async_regs: got %h expected 0", {op_b, op_fxn, result}); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (state_led !== 3'b000) $display("[TB] FAIL rst_idle_state: got %b expected 000", state_led); else passed++;
    total++; if (op_a !== 6'd0) $display("[TB] FAIL rst_idle_op_a: got %0d expected 0", op_a); else passed++;
  endtask

  task automatic test_full_sequence();
    bit found;
    press_enter(6'd21);
    press_enter(6'd10);
    sw = 6'b000001;
    res_in = 6'd31;
    btn_enter = 1'b1;
    wait_op_valid(found);
    total++; if (!found) $display("[TB] FAIL seq_op_valid_timeout: got 0 expected 1"); else passed++;
    total++; if (op_a !== 6'd21) $display("[TB] FAIL seq_op_a: got %0d expected 21", op_a); else passed++;
    total++; if (op_b !== 6'd10) $display("[TB] FAIL seq_op_b: got %0d expected 10", op_b); else passed++;
    total++; if (op_fxn !== 3'd1) $display("[TB] FAIL seq_op_fxn: got %0d expected 1", op_fxn); else passed++;
    total++; if (result_valid !== 1'b0) $display("[TB] FAIL seq_rv_at_issue: got %b expected 0", result_valid); else passed++;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      total++;
      if (result_valid !== (k == 4)) $display("[TB] FAIL seq_rv_latency_%0d: got %b expected %b", k, result_valid, (k == 4));
      else passed++;
    end
    total++; if (result !== 6'd31) $display("[TB] FAIL seq_result: got %0d expected 31", result); else passed++;
    total++; if (state_led !== 3'b100) $display("[TB] FAIL seq_show_state: got %b expected 100", state_led); else passed++;
    btn_enter = 1'b0;
    res_in = 6'd0;
    repeat (12) @(negedge clk);
    total++; if (state_led !== 3'b100) $display("[TB] FAIL seq_release_state: got %b expected 100", state_led); else passed++;
    total++; if (result !== 6'd31) $display("[TB] FAIL seq_show_hold: got %0d expected 31", result); else passed++;
    press_enter(6'd0);
    total++; if ({op_valid, result_valid} !== 2'b00) $display("[TB] FAIL seq_ack_valids: got %b expected 00", {op_valid, result_valid}); else passed++;
    total++; if (state_led !== 3'b000) $display("[TB] FAIL seq_ack_state: got %b expected 000", state_led); else passed++;
    total++; if (op_a !== 6'd21 || result !== 6'd31) $display("[TB] FAIL seq_ack_keep: got a=%0d r=%0d expected a=21 r=31", op_a, result); else passed++;
  endtask

  task automatic test_bounce();
    sw = 6'd9;
    for (int i = 0; i < 5; i++) begin
      btn_enter = 1'b1;
      repeat (2) @(negedge clk);
      btn_enter = 1'b0;
      repeat (2) @(negedge clk);
    end
    total++; if (state_led !== 3'b000 || op_a !== 6'd21) $display("[TB] FAIL bounce_no_load: got st=%b a=%0d expected st=000 a=21", state_led, op_a); else passed++;
    btn_enter = 1'b1;
    repeat (50) @(negedge clk);
    total++; if (op_a !== 6'd9) $display("[TB] FAIL bounce_op_a: got %0d expected 9", op_a); else passed++;
    total++; if (state_led !== 3'b001) $display("[TB] FAIL bounce_one_step: got %b expected 001", state_led); else passed++;
    sw = 6'd63;
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (op_a !== 6'd9) $display("[TB] FAIL bounce_sw_isolated: got %0d expected 9", op_a); else passed++;
    total++; if (state_led !== 3'b001) $display("[TB] FAIL bounce_release_state: got %b expected 001", state_led); else passed++;
  endtask

  task automatic test_clear_priority();
    press_clear();
    total++; if (state_led !== 3'b000 || op_a !== 6'd0) $display("[TB] FAIL clr_basic: got st=%b a=%0d expected st=000 a=0", state_led, op_a); else passed++;
    press_enter(6'd5);
    press_enter(6'd7);
    total++; if (state_led !== 3'b010 || op_b !== 6'd7) $display("[TB] FAIL clr_setup: got st=%b b=%0d expected st=010 b=7", state_led, op_b); else passed++;
    sw = 6'd1;
    btn_enter = 1'b1;
    btn_clear = 1'b1;
    repeat (12) @(negedge clk);
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (state_led !== 3'b000) $display("[TB] FAIL clr_prio_state: got %b expected 000", state_led); else passed++;
    total++; if ({op_a, op_b, op_fxn} !== 15'd0) $display("[TB] FAIL clr_prio_ops: got %h expected 0", {op_a, op_b, op_fxn}); else passed++;
    total++; if (op_valid !== 1'b0) $display("[TB] FAIL clr_prio_valid: got %b expected 0", op_valid); else passed++;
  endtask

  task automatic test_settle_isolation();
    bit found;
    press_enter(6'd3);
    press_enter(6'd4);
    sw = 6'b111010;
    res_in = 6'd12;
    btn_enter = 1'b1;
    wait_op_valid(found);
    total++; if (!found) $display("[TB] FAIL iso_op_valid_timeout: got 0 expected 1"); else passed++;
    @(negedge clk);
    res_in = 6'd40;
    @(negedge clk);
    total++; if (state_led !== 3'b011 || result_valid !== 1'b0) $display("[TB] FAIL iso_in_settle: got st=%b rv=%b expected st=011 rv=0", state_led, result_valid); else passed++;
    total++; if (op_fxn !== 3'd2) $display("[TB] FAIL iso_fxn_low_bits: got %0d expected 2", op_fxn); else passed++;
    repeat (2) @(negedge clk);
    total++; if (result_valid !== 1'b1 || result !== 6'd40) $display("[TB] FAIL iso_capture: got rv=%b r=%0d expected rv=1 r=40", result_valid, result); else passed++;
    btn_enter = 1'b0;
    res_in = 6'd0;
    repeat (12) @(negedge clk);
    total++; if (state_led !== 3'b100) $display("[TB] FAIL iso_enter_ignored: got %b expected 100", state_led); else passed++;
    total++; if (result !== 6'd40) $display("[TB] FAIL iso_show_hold: got %0d expected 40", result); else passed++;
    press_enter(6'd0);
    total++; if (state_led !== 3'b000) $display("[TB] FAIL iso_ack_state: got %b expected 000", state_led); else passed++;
  endtask

  task automatic test_reset_mid_settle();
    bit found;
    bit rvSeen;
    press_enter(6'd7);
    press_enter(6'd8);
    sw = 6'd3;
    res_in = 6'd55;
    btn_enter = 1'b1;
    wait_op_valid(found);
    total++; if (!found) $display("[TB] FAIL mid_op_valid_timeout: got 0 expected 1"); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    btn_enter = 1'b0;
    #1;
    total++; if ({op_a, op_b, op_fxn, result} !== 21'd0) $display("[TB] FAIL mid_rst_regs: got %h expected 0", {op_a, op_b, op_fxn, result}); else passed++;
    total++; if ({op_valid, result_valid, state_led} !== 5'd0) $display("[TB] FAIL mid_rst_ctrl: got %b expected 00000", {op_valid, result_valid, state_led}); else passed++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rvSeen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (result_valid !== 1'b0) rvSeen = 1'b1;
    end
    total++; if (rvSeen) $display("[TB] FAIL mid_no_capture: got rv seen=1 expected 0"); else passed++;
    total++; if (state_led !== 3'b000 || result !== 6'd0) $display("[TB] FAIL mid_after_state: got st=%b r=%0d expected st=000 r=0", state_led, result); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    sw = '0;
    btn_enter = 1'b0;
    btn_clear = 1'b0;
    res_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_sequence();
    test_bounce();
    test_clear_priority();
    test_settle_isolation();
    test_reset_mid_settle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
